control_sequencer: RTL and testbench

- Moore-style control unit that drives the datapath's control strobes.
- It steps fetch (T0-T2) and execute (T3-T6) phases from the instruction register.
- It replaces hand-driven bench stimulus: it is the producer side of the datapath control interface, and the datapath is the consumer.
- It sits beside the datapath. It reads `ir` from the datapath and drives every Rin/Rout/strobe and the ALU opcode.

---
 rtl/control_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_control_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer
//   Moore-style control unit for the single-bus datapath. Steps the fetch
//   phase (T0-T2) and the execute phase (T3-T6) of each instruction. All
//   strobes are combinational functions of the current state and of the
//   instruction register, so they follow state changes without a register
//   stage.
//
// Ports
//   clk      system clock; every state change is on its rising edge
//   clr      asynchronous active-low reset; forces IDLE, all outputs 0
//   ir       datapath IR: [31:27] opcode, [26:23] Ra, [22:19] Rb, [18:15] Rc
//   stop     request to halt at the next instruction boundary
//   PCout .. LOin  single-bit datapath strobes
//   Rin      one-hot register write enable (NREG wide)
//   Rout     one-hot register bus drive (NREG wide)
//   opcode   ALU operation select; nonzero only in T4
//   run      high while sequencing (T0-T6)
//   illegal  high during T3 of an unsupported opcode
module control_sequencer #(
   parameter int NREG = 16,
   parameter int IRW  = 32
) (
   input  logic            clk,
   input  logic            clr,
   input  logic [IRW-1:0]  ir,
   input  logic            stop,
   output logic            PCout,
   output logic            incPC,
   output logic            MARin,
   output logic            Zin,
   output logic            ZLowOut,
   output logic            ZHighOut,
   output logic            PCin,
   output logic            Read,
   output logic            MDRin,
   output logic            MDRout,
   output logic            IRin,
   output logic            Yin,
   output logic            HIin,
   output logic            LOin,
   output logic [NREG-1:0] Rin,
   output logic [NREG-1:0] Rout,
   output logic [4:0]      opcode,
   output logic            run,
   output logic            illegal
);

   typedef enum logic [3:0] {
      IDLE, T0, T1, T2, T3, T4, T5, T6, HALTED
   } state_t;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_SHR  = 5'b00101;
   localparam logic [4:0] OP_SHL  = 5'b00110;
   localparam logic [4:0] OP_AND  = 5'b01010;
   localparam logic [4:0] OP_OR   = 5'b01011;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   state_t state_reg, state_next;

   // Instruction field decode
   logic [4:0] ir_op;
   logic [3:0] ir_ra, ir_rb, ir_rc;
   logic       is_alu, is_muldiv, is_nop, is_halt, is_legal;
   logic       unused_ir_bits;

   assign ir_op  = ir[31:27];
   assign ir_ra  = ir[26:23];
   assign ir_rb  = ir[22:19];
   assign ir_rc  = ir[18:15];
   assign unused_ir_bits = ^ir[14:0];

   assign is_alu    = (ir_op == OP_ADD) || (ir_op == OP_SUB) || (ir_op == OP_SHR) ||
                      (ir_op == OP_SHL) || (ir_op == OP_AND) || (ir_op == OP_OR);
   assign is_muldiv = (ir_op == OP_MUL) || (ir_op == OP_DIV);
   assign is_nop    = (ir_op == OP_NOP);
   assign is_halt   = (ir_op == OP_HALT);
   assign is_legal  = is_alu || is_muldiv || is_nop || is_halt;

   // State register
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) state_reg <= IDLE;
      else      state_reg <= state_next;
   end

   // Next-state logic; the boundary decision (stop) is only taken in the
   // last state of an instruction and in IDLE.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:   state_next = stop ? IDLE : T0;
         T0:     state_next = T1;
         T1:     state_next = T2;
         T2:     state_next = T3;
         T3: begin
            if (is_halt)                     state_next = HALTED;
            else if (is_alu || is_muldiv)    state_next = T4;
            else                             state_next = stop ? IDLE : T0;
         end
         T4:     state_next = T5;
         T5:     state_next = is_muldiv ? T6 : (stop ? IDLE : T0);
         T6:     state_next = stop ? IDLE : T0;
         HALTED: state_next = HALTED;
         default: state_next = IDLE;
      endcase
   end

   // Register-select request: an enable plus a 4-bit index, expanded to
   // one-hot below so at most one bit can ever be set.
   logic       rin_en, rout_en;
   logic [3:0] rin_sel, rout_sel;

   always_comb begin
      PCout    = 1'b0;
      incPC    = 1'b0;
      MARin    = 1'b0;
      Zin      = 1'b0;
      ZLowOut  = 1'b0;
      ZHighOut = 1'b0;
      PCin     = 1'b0;
      Read     = 1'b0;
      MDRin    = 1'b0;
      MDRout   = 1'b0;
      IRin     = 1'b0;
      Yin      = 1'b0;
      HIin     = 1'b0;
      LOin     = 1'b0;
      opcode   = 5'd0;
      run      = 1'b0;
      illegal  = 1'b0;
      rin_en   = 1'b0;
      rin_sel  = 4'd0;
      rout_en  = 1'b0;
      rout_sel = 4'd0;
      case (state_reg)
         T0: begin
            run = 1'b1; PCout = 1'b1; MARin = 1'b1; incPC = 1'b1; Zin = 1'b1;
         end
         T1: begin
            run = 1'b1; ZLowOut = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
         end
         T2: begin
            run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
         end
         T3: begin
            run = 1'b1;
            if (is_alu || is_muldiv) begin
               // ALU ops take the first operand from Rb, MUL/DIV from Ra
               rout_en  = 1'b1;
               rout_sel = is_alu ? ir_rb : ir_ra;
               Yin      = 1'b1;
            end
            illegal = !is_legal;
         end
         T4: begin
            run = 1'b1;
            if (is_alu || is_muldiv) begin
               rout_en  = 1'b1;
               rout_sel = is_alu ? ir_rc : ir_rb;
               opcode   = ir_op;
               Zin      = 1'b1;
            end
         end
         T5: begin
            run = 1'b1;
            if (is_alu) begin
               ZLowOut = 1'b1;
               rin_en  = 1'b1;
               rin_sel = ir_ra;
            end else if (is_muldiv) begin
               ZLowOut = 1'b1;
               LOin    = 1'b1;
            end
         end
         T6: begin
            run = 1'b1;
            if (is_muldiv) begin
               ZHighOut = 1'b1;
               HIin     = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // One-hot expansion of the register selects
   for (genvar gi = 0; gi < NREG; gi++) begin : g_reg_dec
      localparam logic [3:0] IDX = 4'(gi);
      assign Rin[gi]  = rin_en  && (rin_sel  == IDX);
      assign Rout[gi] = rout_en && (rout_sel == IDX);
   end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

   typedef struct packed {
      logic [13:0] strb;
      logic [15:0] rin;
      logic [15:0] rout;
      logic [4:0]  opc;
      logic        run;
      logic        ill;
   } rec_t;

   // strobe bit positions inside rec_t.strb
   localparam logic [13:0] M_PCOUT  = 14'h0001;
   localparam logic [13:0] M_INCPC  = 14'h0002;
   localparam logic [13:0] M_MARIN  = 14'h0004;
   localparam logic [13:0] M_ZIN    = 14'h0008;
   localparam logic [13:0] M_ZLOW   = 14'h0010;
   localparam logic [13:0] M_ZHIGH  = 14'h0020;
   localparam logic [13:0] M_PCIN   = 14'h0040;
   localparam logic [13:0] M_READ   = 14'h0080;
   localparam logic [13:0] M_MDRIN  = 14'h0100;
   localparam logic [13:0] M_MDROUT = 14'h0200;
   localparam logic [13:0] M_IRIN   = 14'h0400;
   localparam logic [13:0] M_YIN    = 14'h0800;
   localparam logic [13:0] M_HIIN   = 14'h1000;
   localparam logic [13:0] M_LOIN   = 14'h2000;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic [31:0] ir = 32'd0;
   logic        stop = 1'b0;
   logic PCout, incPC, MARin, Zin, ZLowOut, ZHighOut, PCin, Read;
   logic MDRin, MDRout, IRin, Yin, HIin, LOin, run, illegal;
   logic [15:0] Rin, Rout;
   logic [4:0]  opcode;

   control_sequencer #(.NREG(16), .IRW(32)) dut (
      .clk(clk), .clr(clr), .ir(ir), .stop(stop),
      .PCout(PCout), .incPC(incPC), .MARin(MARin), .Zin(Zin),
      .ZLowOut(ZLowOut), .ZHighOut(ZHighOut), .PCin(PCin), .Read(Read),
      .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
      .HIin(HIin), .LOin(LOin), .Rin(Rin), .Rout(Rout),
      .opcode(opcode), .run(run), .illegal(illegal)
   );

   always #5 clk = ~clk;

   rec_t act;
   assign act = {LOin, HIin, Yin, IRin, MDRout, MDRin, Read, PCin,
                 ZHighOut, ZLowOut, Zin, MARin, incPC, PCout,
                 Rin, Rout, opcode, run, illegal};

   rec_t exp_q[$];
   rec_t plan_q[$];
   logic plan_halts;
   int   checks = 0;
   int   errors = 0;

   function automatic rec_t fr(input logic [13:0] s);
      rec_t r;
      r = '0;
      r.strb = s;
      r.run  = 1'b1;
      return r;
   endfunction

   // Reference model: the cycle-by-cycle output list of one instruction,
   // built straight from the instruction rules.
   function automatic void build_plan(input logic [31:0] iv);
      logic [4:0] op;
      logic [3:0] ra, rb, rc;
      rec_t r;
      op = iv[31:27];
      ra = iv[26:23];
      rb = iv[22:19];
      rc = iv[18:15];
      plan_q.delete();
      plan_halts = 1'b0;
      plan_q.push_back(fr(M_PCOUT | M_MARIN | M_INCPC | M_ZIN));
      plan_q.push_back(fr(M_ZLOW | M_PCIN | M_READ | M_MDRIN));
      plan_q.push_back(fr(M_MDROUT | M_IRIN));
      if (op inside {5'd3, 5'd4, 5'd5, 5'd6, 5'd10, 5'd11}) begin
         r = fr(M_YIN);  r.rout = 16'd1 << rb;               plan_q.push_back(r);
         r = fr(M_ZIN);  r.rout = 16'd1 << rc; r.opc = op;   plan_q.push_back(r);
         r = fr(M_ZLOW); r.rin  = 16'd1 << ra;               plan_q.push_back(r);
      end else if (op inside {5'd15, 5'd16}) begin
         r = fr(M_YIN);  r.rout = 16'd1 << ra;               plan_q.push_back(r);
         r = fr(M_ZIN);  r.rout = 16'd1 << rb; r.opc = op;   plan_q.push_back(r);
         plan_q.push_back(fr(M_ZLOW | M_LOIN));
         plan_q.push_back(fr(M_ZHIGH | M_HIIN));
      end else if (op == 5'd26) begin
         plan_q.push_back(fr(14'd0));
      end else if (op == 5'd27) begin
         plan_q.push_back(fr(14'd0));
         plan_halts = 1'b1;
      end else begin
         r = fr(14'd0); r.ill = 1'b1;                        plan_q.push_back(r);
      end
   endfunction

   // One clock cycle: apply inputs just after the edge and queue the
   // outputs expected for the rest of this cycle.
   task automatic step(input rec_t e, input logic sv, input logic cv, input logic [31:0] iv);
      @(posedge clk);
      #1;
      stop = sv;
      clr  = cv;
      ir   = iv;
      exp_q.push_back(e);
   endtask

   task automatic run_instr(input logic [31:0] iv, input logic want_stop, input int abort_k);
      int   n;
      int   nidle;
      logic sv;
      build_plan(iv);
      n = plan_q.size();
      $display("instr ir=%08h stop=%0d abort=%0d cycles=%0d", iv, want_stop, abort_k, n);
      for (int k = 0; k < n; k++) begin
         if (k == abort_k) begin
            // clr drops between edges: outputs must already be 0 this cycle
            step('0, 1'b0, 1'b0, ir);
            step('0, 1'b0, 1'b1, ir);
            return;
         end
         sv = (k == n - 1 && !plan_halts) ? want_stop : 1'($urandom_range(0, 1));
         step(plan_q[k], sv, 1'b1, (k == 0) ? iv : ir);
      end
      if (plan_halts) begin
         for (int j = 0; j < 20; j++) step('0, 1'($urandom_range(0, 1)), 1'b1, ir);
         step('0, 1'b0, 1'b0, ir);
         step('0, 1'b0, 1'b1, ir);
      end else if (want_stop) begin
         nidle = $urandom_range(1, 3);
         for (int j = 0; j < nidle; j++) step('0, (j < nidle - 1), 1'b1, ir);
      end
   endtask

   // Monitor: every cycle that has an expectation queued is compared
   initial begin
      rec_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act !== e) begin
               errors++;
               $display("FAIL outputs t=%0t: got strb=%04h rin=%04h rout=%04h opc=%02h run=%b ill=%b, expected strb=%04h rin=%04h rout=%04h opc=%02h run=%b ill=%b",
                        $time, act.strb, act.rin, act.rout, act.opc, act.run, act.ill,
                        e.strb, e.rin, e.rout, e.opc, e.run, e.ill);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not end, expected finish before 500000");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] iv;
      logic [4:0]  op;
      int          sel, ab;
      logic [4:0]  legal_ops [10];
      legal_ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd10, 5'd11, 5'd15, 5'd16, 5'd26, 5'd27};

      step('0, 1'b0, 1'b0, 32'd0);
      step('0, 1'b0, 1'b0, 32'd0);
      step('0, 1'b0, 1'b1, 32'd0);

      run_instr(32'h50918000, 1'b0, -1);   // AND R1,R2,R3
      run_instr(32'h7A280000, 1'b0, -1);   // MUL R4,R5
      run_instr(32'hF8000000, 1'b0, -1);   // unsupported opcode
      run_instr(32'h18918000, 1'b1, -1);   // ADD with stop at boundary
      run_instr(32'h18918000, 1'b0, 4);    // reset during T4
      run_instr(32'h00000000, 1'b0, -1);   // opcode 0 is unsupported, R0 fields
      run_instr(32'hD8000000, 1'b0, -1);   // HALT

      for (int i = 0; i < 80; i++) begin
         iv  = $urandom;
         sel = $urandom_range(0, 11);
         if (sel < 10) begin
            op = legal_ops[sel];
            if (op == 5'd27 && $urandom_range(0, 2) != 0) op = 5'd3;
         end else begin
            op = 5'($urandom_range(0, 31));
            while (op inside {5'd3, 5'd4, 5'd5, 5'd6, 5'd10, 5'd11, 5'd15, 5'd16, 5'd26, 5'd27})
               op = 5'($urandom_range(0, 31));
         end
         iv[31:27] = op;
         ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 6) : -1;
         run_instr(iv, ($urandom_range(0, 3) == 0), ab);
      end

      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
